bat_bus_arbiter: RTL and testbench
==================================

# bat_bus_arbiter

Round-robin arbiter that shares the single 8-bit system bus (RAM, MAR, register file) between the microcoded CPU sequencer, the front-panel RAM loader and the output/DMA port. Each requester raises a level request. The arbiter grants exactly one owner at a time and inserts a one-cycle turnaround gap between owners so that two bus drivers are never enabled together. It updates on the falling clock edge, matching the CPU sequencer, so grants are stable before any rising-edge register load.

## Interface
- N_REQ, 3, number of requesters; index 0 = CPU sequencer, 1 = loader, 2 = output port.
- MAX_HOLD, 8, maximum owned cycles before preemption when another request is pending; must be ≥1.
- CLK  in  1  system clock; all state changes on negedge CLK.
- RST  in  1  reset, asynchronous, active-low.
- REQ  in  N_REQ  level request per requester; held high for as long as bus ownership is wanted.
- GNT  out  N_REQ  one-hot grant, or all zero; the owner may enable bus drivers only while its bit is high.
- OWNER  out  $clog2(N_REQ)  index of the current or last owner.
- BUS_BUSY  out  1  high while in OWN.
- PREEMPT  out  1  one-cycle pulse on a forced release (timeout build only; tied 0 otherwise).

## Operation
- **Reset values:** GNT=0, OWNER=0, BUS_BUSY=0, PREEMPT=0, state=IDLE, last-owner pointer=N_REQ-1 (requester 0 wins first), hold counter=0.
- **States:**
  - IDLE: no owner. If any REQ is high → OWN, granting the winner. Otherwise stay in IDLE.
  - OWN: GNT[owner]=1, BUS_BUSY=1. If REQ[owner] is low → GAP. If the timeout fires → GAP with PREEMPT. Otherwise stay in OWN.
  - GAP: GNT=0 for exactly one cycle. If any REQ is high → OWN, granting the new winner. Otherwise → IDLE.
- **Round-robin:** search starts at last-owner+1 and wraps modulo N_REQ. The first requester with REQ high wins. The pointer updates to the winner on each grant.
- **Re-request:** an owner that releases and re-requests during GAP competes at lowest priority. It can win again only if no other REQ is high.
- **Level sensitivity:** a REQ that drops before being granted is simply not granted. Nothing is latched.
- **Grant encoding:** GNT is always one-hot or zero. OWNER holds its value through GAP and IDLE.

## Timing
- **Grant latency:** REQ high before negedge k while in IDLE → GNT high after negedge k, i.e. zero-wait grant.
- **Release:** REQ[owner] low before negedge k → GNT=0 after k. Next grant is no earlier than negedge k+1, giving one full cycle of bus turnaround.
- **Back-to-back owners:** minimum of one GAP cycle between consecutive grants.
- **Simultaneous release and timeout:** treated as a normal release; PREEMPT stays 0.
- **Reset mid-ownership:** GNT drops asynchronously to 0 as soon as RST asserts. After deassertion the arbiter starts in IDLE with requester 0 at top priority.
- **REQ inputs:** synchronous to CLK; they must be stable around the negedge.

## Configuration
- **BAT_BUS_ARB_TIMEOUT_EN defined:**
  - The hold counter, width $clog2(MAX_HOLD+1), loads 1 on the grant edge and increments each negedge in OWN, saturating at MAX_HOLD.
  - If the counter equals MAX_HOLD at a negedge and any other REQ is high → GAP, with PREEMPT high for that GAP cycle.
  - With no competing request, ownership continues indefinitely.
  - A preempted requester that keeps REQ high is re-granted later in normal rotation.
- **BAT_BUS_ARB_TIMEOUT_EN undefined:** no counter is built, PREEMPT is tied 0, and the owner keeps the bus until it drops REQ.

## Structure
- **Package bat_bus_pkg:**
  - state enum {IDLE, OWN, GAP};
  - requester index constants REQ_CPU=0, REQ_LOADER=1, REQ_OUT=2;
  - default N_REQ and MAX_HOLD.
- **Sub-module bat_rr_picker:** combinational. Inputs are REQ and the last-owner pointer; outputs are a valid flag and the winner index. It is the only place the wrap-around search is implemented.
- **Top level:** state register, pointer, optional counter, and output registers.

## Test plan
- **Reset and first grant:** hold RST low with REQ=3'b111, then release. GNT=0 during reset. At the first negedge GNT=3'b001, OWNER=0, BUS_BUSY=1.
- **Rotation:** REQ=3'b111 held, with each owner dropping REQ for one cycle after 2 owned cycles. Grant order is 0,1,2,0, with exactly one GNT=0 gap cycle between owners.
- **Solo re-request:** only REQ[1] is high. It drops for one cycle, then rises during GAP. The sequence is GNT=3'b010, then 0 for one cycle, then 3'b010 again. No other bit ever goes high.
- **Timeout (macro on, MAX_HOLD=8):** REQ[0] held high, REQ[2] rises at cycle 3. GNT[0] lasts 8 cycles, then a GAP with PREEMPT=1, then GNT=3'b100.
- **Timeout with no competitor:** only REQ[0] is high for 20 cycles. GNT=3'b001 for all 20 cycles and PREEMPT never pulses. The same result is required with the macro off.
- **Async reset mid-OWN:** assert RST while GNT=3'b010. GNT=0 immediately, before the next CLK edge. After release, requester 0 has priority.

Source files
------------

// File: rtl/bat_bus_pkg.sv
// Shared types and defaults for the bat system-bus arbiter.
// Optional macro used by the arbiter: BAT_BUS_ARB_TIMEOUT_EN.
package bat_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_e;

    localparam int REQ_CPU    = 0;
    localparam int REQ_LOADER = 1;
    localparam int REQ_OUT    = 2;

    localparam int N_REQ_DEF    = 3;
    localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/bat_bus_if.sv
// Request/grant bundle between the bus requesters and the arbiter.
// The arbiter side uses the master modport, requesters use slave.
interface bat_bus_if import bat_bus_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] REQ;
    logic [N_REQ-1:0] GNT;
    logic [IW-1:0]    OWNER;
    logic             BUS_BUSY;
    logic             PREEMPT;

    modport master (
        input  REQ,
        output GNT,
        output OWNER,
        output BUS_BUSY,
        output PREEMPT
    );

    modport slave (
        output REQ,
        input  GNT,
        input  OWNER,
        input  BUS_BUSY,
        input  PREEMPT
    );

endinterface

// File: rtl/bat_rr_picker.sv
// Combinational round-robin search: first active request after `last`,
// wrapping modulo N_REQ, so the previous owner has lowest priority.
module bat_rr_picker import bat_bus_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(last) + i) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bat_bus_arbiter.sv
// Round-robin owner arbiter for the shared 8-bit bus, negedge-clocked,
// with a one-cycle GAP between owners. Macro: BAT_BUS_ARB_TIMEOUT_EN.
module bat_bus_arbiter import bat_bus_pkg::*; #(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    bat_bus_if.master  bus
);

    localparam int IW = $clog2(N_REQ);

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;
    logic             win_vld;
    logic [IW-1:0]    win;
    logic             timeout;

    bat_rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.REQ),
        .last  (ptr_q),
        .valid (win_vld),
        .idx   (win)
    );

`ifdef BAT_BUS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;

    // Preempt only when someone else is actually waiting.
    assign timeout = (hold_q == HW'(MAX_HOLD))
                   && |(bus.REQ & ~gnt_q);

    always_comb begin
        hold_d = hold_q;
        if (state_q == OWN) begin
            if (hold_q != HW'(MAX_HOLD))
                hold_d = hold_q + HW'(1);
        end else begin
            hold_d = win_vld ? HW'(1) : '0;
        end
    end

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) hold_q <= '0;
        else      hold_q <= hold_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (win_vld) begin
                    state_d    = OWN;
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    ptr_d      = win;
                    busy_d     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                // A plain release wins over a coincident timeout.
                if (!bus.REQ[owner_q] || timeout) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    preempt_d = bus.REQ[owner_q];
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= IW'(N_REQ - 1);
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.GNT      = gnt_q;
    assign bus.OWNER    = owner_q;
    assign bus.BUS_BUSY = busy_q;
    assign bus.PREEMPT  = preempt_q;

endmodule

// File: tb/tb_bat_bus_arbiter.sv
// Directed scoreboard bench for bat_bus_arbiter (N_REQ=3, MAX_HOLD=8),
// expectations switch with BAT_BUS_ARB_TIMEOUT_EN.
module tb_bat_bus_arbiter;

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] own;
        logic       busy;
        logic       pre;
    } exp_t;

    logic CLK;
    logic RST;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    bat_bus_if #(.N_REQ(3)) bus ();

    bat_bus_arbiter #(
        .N_REQ    (3),
        .MAX_HOLD (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input exp_t e);
        exp_t o;
        o = {bus.GNT, bus.OWNER, bus.BUS_BUSY, bus.PREEMPT};
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: got gnt=%b own=%0d busy=%b pre=%b, expected gnt=%b own=%0d busy=%b pre=%b",
                   tag, o.gnt, o.own, o.busy, o.pre,
                   e.gnt, e.own, e.busy, e.pre);
        end
    endtask

    // Drive REQ mid-cycle, expect the result of the following negedge.
    task automatic cyc(input string tag, input logic [2:0] r,
                       input logic [2:0] g, input logic [1:0] o,
                       input logic b, input logic p);
        exp_t e;
        @(posedge CLK);
        bus.REQ = r;
        e = '{gnt: g, own: o, busy: b, pre: p};
        sb.push_back(e);
        @(negedge CLK);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, e);
        end
    endtask

    initial begin
        exp_t z;
        z      = '0;
        n_chk  = 0;
        n_fail = 0;
        RST     = 1'b0;
        bus.REQ = 3'b111;

        repeat (2) @(negedge CLK);
        #1;
        chk("reset", z);
        RST = 1'b1;
        cyc("first_grant", 3'b111, 3'b001, 2'd0, 1'b1, 1'b0);

        cyc("rot_0b", 3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
        cyc("rot_gap0", 3'b110, 3'b000, 2'd0, 1'b0, 1'b0);
        cyc("rot_1a", 3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
        cyc("rot_1b", 3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
        cyc("rot_gap1", 3'b101, 3'b000, 2'd1, 1'b0, 1'b0);
        cyc("rot_2a", 3'b111, 3'b100, 2'd2, 1'b1, 1'b0);
        cyc("rot_2b", 3'b111, 3'b100, 2'd2, 1'b1, 1'b0);
        cyc("rot_gap2", 3'b011, 3'b000, 2'd2, 1'b0, 1'b0);
        cyc("rot_0c", 3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
        cyc("rot_0d", 3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
        cyc("rot_gap3", 3'b110, 3'b000, 2'd0, 1'b0, 1'b0);
        cyc("rot_idle", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        cyc("idle_hold", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

        cyc("solo_g1", 3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        cyc("solo_g2", 3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        cyc("solo_gap", 3'b000, 3'b000, 2'd1, 1'b0, 1'b0);
        cyc("solo_regnt", 3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        cyc("solo_g3", 3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        cyc("solo_gap2", 3'b000, 3'b000, 2'd1, 1'b0, 1'b0);
        cyc("solo_idle", 3'b000, 3'b000, 2'd1, 1'b0, 1'b0);

        cyc("rr_wrap0", 3'b011, 3'b001, 2'd0, 1'b1, 1'b0);
        cyc("rr_gap", 3'b010, 3'b000, 2'd0, 1'b0, 1'b0);
        cyc("rr_lowpri", 3'b011, 3'b010, 2'd1, 1'b1, 1'b0);
        cyc("rr_gap2", 3'b001, 3'b000, 2'd1, 1'b0, 1'b0);
        cyc("rr_idle", 3'b000, 3'b000, 2'd1, 1'b0, 1'b0);

        for (int i = 1; i <= 20; i++)
            cyc($sformatf("nocomp_%0d", i), 3'b001,
                3'b001, 2'd0, 1'b1, 1'b0);
        cyc("nocomp_gap", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        cyc("nocomp_idle", 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

        for (int i = 1; i <= 8; i++)
            cyc($sformatf("to_hold%0d", i),
                (i < 3) ? 3'b001 : 3'b101,
                3'b001, 2'd0, 1'b1, 1'b0);
`ifdef BAT_BUS_ARB_TIMEOUT_EN
        cyc("to_preempt", 3'b101, 3'b000, 2'd0, 1'b0, 1'b1);
        cyc("to_regrant", 3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
`else
        cyc("to_nopre1", 3'b101, 3'b001, 2'd0, 1'b1, 1'b0);
        cyc("to_nopre2", 3'b101, 3'b001, 2'd0, 1'b1, 1'b0);
        cyc("to_rel", 3'b100, 3'b000, 2'd0, 1'b0, 1'b0);
        cyc("to_g2", 3'b100, 3'b100, 2'd2, 1'b1, 1'b0);
`endif
        cyc("to_drop", 3'b000, 3'b000, 2'd2, 1'b0, 1'b0);
        cyc("to_idle", 3'b000, 3'b000, 2'd2, 1'b0, 1'b0);

        cyc("ar_own1", 3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
        #2;
        RST     = 1'b0;
        bus.REQ = 3'b111;
        #1;
        chk("ar_async", z);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        cyc("ar_prio0", 3'b111, 3'b001, 2'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
